// File: rtl/ce_moving_average.sv
// Boxcar moving-average filter over the last 2**WINDOW_LOG2 CE-qualified samples.
// CE_OUT only fires once the window holds a full set of post-reset samples.
module ce_moving_average #(
    parameter int DATA_BITS   = 16,
    parameter int WINDOW_LOG2 = 4
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             CE,
    input  logic [DATA_BITS-1:0]             DATA_IN,
    output logic [DATA_BITS+WINDOW_LOG2-1:0] SUM_OUT,
    output logic [DATA_BITS-1:0]             DATA_OUT,
    output logic                             CE_OUT,
    output logic                             FILLED
);

    localparam int N      = 1 << WINDOW_LOG2;
    localparam int SUM_W  = DATA_BITS + WINDOW_LOG2;
    localparam int FILL_W = WINDOW_LOG2 + 1;
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(N - 1);

    typedef enum logic [0:0] {
        FILLING = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_BITS-1:0]    ring_q [N];
    logic [WINDOW_LOG2-1:0]  ptr_q;
    logic [WINDOW_LOG2-1:0]  ptr_d;
    logic [FILL_W-1:0]       fill_q;
    logic [FILL_W-1:0]       fill_d;
    logic [SUM_W-1:0]        sum_q;
    logic [SUM_W-1:0]        sum_d;
    logic [SUM_W-1:0]        sum_out_q;
    logic [DATA_BITS-1:0]    data_out_q;
    logic                    ce_out_q;
    logic                    filled_q;
    logic [DATA_BITS-1:0]    old_s;
    logic                    full_after_s;

    function automatic logic [DATA_BITS-1:0] scale_down(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:WINDOW_LOG2];
    endfunction

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= FILLING;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave FILLING on the CE that writes the N-th sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILLING: begin
                if (CE && (fill_q == LAST_FILL)) begin
                    state_d = RUNNING;
                end else begin
                    state_d = FILLING;
                end
            end
            RUNNING: state_d = RUNNING;
            default: state_d = FILLING;
        endcase
    end

    // Per-state datapath controls; RAM contents are masked until the window is full
    always_comb begin
        old_s        = '0;
        full_after_s = 1'b0;
        fill_d       = fill_q;
        case (state_q)
            FILLING: begin
                old_s        = '0;
                full_after_s = (fill_q == LAST_FILL);
                if (CE) begin
                    fill_d = fill_q + FILL_W'(1);
                end else begin
                    fill_d = fill_q;
                end
            end
            RUNNING: begin
                old_s        = ring_q[ptr_q];
                full_after_s = 1'b1;
                fill_d       = fill_q;
            end
            default: begin
                old_s        = '0;
                full_after_s = 1'b0;
                fill_d       = fill_q;
            end
        endcase
    end

    // Accumulator and pointer next values
    always_comb begin
        sum_d = sum_q;
        ptr_d = ptr_q;
        if (CE) begin
            sum_d = sum_q + SUM_W'(DATA_IN) - SUM_W'(old_s);
            ptr_d = ptr_q + WINDOW_LOG2'(1);
        end else begin
            sum_d = sum_q;
            ptr_d = ptr_q;
        end
    end

    // Window state and output register; reset has priority over CE
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ptr_q      <= '0;
            fill_q     <= '0;
            sum_q      <= '0;
            sum_out_q  <= '0;
            data_out_q <= '0;
            ce_out_q   <= 1'b0;
            filled_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
            sum_q  <= sum_d;
            if (CE) begin
                sum_out_q  <= sum_d;
                data_out_q <= scale_down(sum_d);
                ce_out_q   <= full_after_s;
                filled_q   <= filled_q | full_after_s;
            end else begin
                ce_out_q <= 1'b0;
            end
        end
    end

    // Ring buffer write; never cleared, so reads are gated by state above
    always_ff @(posedge CLK) begin
        if (RESET_N && CE) begin
            ring_q[ptr_q] <= DATA_IN;
        end
    end

    assign SUM_OUT  = sum_out_q;
    assign DATA_OUT = data_out_q;
    assign CE_OUT   = ce_out_q;
    assign FILLED   = filled_q;

endmodule

// File: tb/tb_ce_moving_average.sv
// Directed bench for ce_moving_average (DATA_BITS=8, N=4) with a window-model scoreboard.
module tb_ce_moving_average;

    localparam int DB = 8;
    localparam int WL = 2;
    localparam int N  = 4;
    localparam int SW = DB + WL;

    logic          CLK     = 1'b0;
    logic          RESET_N = 1'b0;
    logic          CE      = 1'b0;
    logic [DB-1:0] DATA_IN = '0;
    logic [SW-1:0] SUM_OUT;
    logic [DB-1:0] DATA_OUT;
    logic          CE_OUT;
    logic          FILLED;

    ce_moving_average #(.DATA_BITS(DB), .WINDOW_LOG2(WL)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .DATA_IN(DATA_IN),
        .SUM_OUT(SUM_OUT), .DATA_OUT(DATA_OUT), .CE_OUT(CE_OUT), .FILLED(FILLED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [SW-1:0] sum;
        logic [DB-1:0] avg;
        logic          ce;
        logic          filled;
    } exp_t;

    exp_t sb_q[$];
    int   win_q[$];
    int   seen = 0;
    exp_t last_e;
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int v, input string tag);
        int   s;
        exp_t e;
        exp_t got;
        CE      = 1'b1;
        DATA_IN = v[DB-1:0];
        win_q.push_back(v);
        if (win_q.size() > N) void'(win_q.pop_front());
        seen++;
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        e.sum    = SW'(s);
        e.avg    = DB'(s >> WL);
        e.ce     = (seen >= N);
        e.filled = (seen >= N);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        CE  = 1'b0;
        got = sb_q.pop_front();
        check({tag, "_sum"},    32'(SUM_OUT),  32'(got.sum));
        check({tag, "_avg"},    32'(DATA_OUT), 32'(got.avg));
        check({tag, "_ceout"},  32'(CE_OUT),   32'(got.ce));
        check({tag, "_filled"}, 32'(FILLED),   32'(got.filled));
        last_e = got;
    endtask

    task automatic idle(input int n, input string tag);
        CE = 1'b0;
        for (int i = 0; i < n; i++) begin
            DATA_IN = DB'($urandom_range(0, 255));
            @(posedge CLK);
            #1;
            check({tag, "_ceout_gap"},  32'(CE_OUT),   32'(0));
            check({tag, "_sum_hold"},   32'(SUM_OUT),  32'(last_e.sum));
            check({tag, "_avg_hold"},   32'(DATA_OUT), 32'(last_e.avg));
            check({tag, "_filled_hold"}, 32'(FILLED),  32'(last_e.filled));
        end
    endtask

    task automatic do_reset(input logic ce_v, input int d, input string tag);
        RESET_N = 1'b0;
        CE      = ce_v;
        DATA_IN = d[DB-1:0];
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        CE      = 1'b0;
        win_q.delete();
        seen          = 0;
        last_e.sum    = '0;
        last_e.avg    = '0;
        last_e.ce     = 1'b0;
        last_e.filled = 1'b0;
        check({tag, "_sum"},    32'(SUM_OUT),  32'(0));
        check({tag, "_avg"},    32'(DATA_OUT), 32'(0));
        check({tag, "_ceout"},  32'(CE_OUT),   32'(0));
        check({tag, "_filled"}, 32'(FILLED),   32'(0));
    endtask

    initial begin
        do_reset(1'b0, 0, "rst0");

        // Gap-free fill, then pointer wrap
        sample(10, "a10");
        sample(20, "a20");
        sample(30, "a30");
        sample(40, "a40");
        check("a40_sum_100", 32'(SUM_OUT), 32'(100));
        check("a40_avg_25",  32'(DATA_OUT), 32'(25));
        sample(50, "a50");
        check("a50_sum_140", 32'(SUM_OUT), 32'(140));
        sample(60, "a60");
        check("a60_sum_180", 32'(SUM_OUT), 32'(180));
        check("a60_avg_45",  32'(DATA_OUT), 32'(45));

        // Same stream with 3 idle cycles between samples
        do_reset(1'b0, 0, "rst1");
        sample(10, "g10"); idle(3, "g1");
        sample(20, "g20"); idle(3, "g2");
        sample(30, "g30"); idle(3, "g3");
        sample(40, "g40"); idle(3, "g4");
        check("g40_sum_100", 32'(SUM_OUT), 32'(100));
        sample(50, "g50"); idle(3, "g5");
        sample(60, "g60");
        check("g60_sum_180", 32'(SUM_OUT), 32'(180));

        // Full-scale samples, no wrap of the sum
        do_reset(1'b0, 0, "rst2");
        for (int i = 0; i < N; i++) sample(255, "m255");
        check("m255_sum_1020", 32'(SUM_OUT), 32'(1020));
        check("m255_avg_255",  32'(DATA_OUT), 32'(255));
        sample(0, "m0");
        check("m0_sum_765", 32'(SUM_OUT), 32'(765));
        check("m0_avg_191", 32'(DATA_OUT), 32'(191));

        // Stale buffer contents must not leak after reset
        for (int i = 0; i < 6; i++) sample(200, "s200");
        do_reset(1'b0, 0, "rst3");
        for (int i = 0; i < N; i++) sample(1, "s1");
        check("s1_sum_4", 32'(SUM_OUT), 32'(4));
        check("s1_avg_1", 32'(DATA_OUT), 32'(1));

        // Reset wins over a simultaneous CE sample
        sample(7, "p7");
        do_reset(1'b1, 99, "rst4");
        sample(5, "r5");
        sample(6, "r6");
        sample(7, "r7");
        sample(8, "r8");
        check("r8_sum_26", 32'(SUM_OUT), 32'(26));
        idle(2, "r");
        sample(9, "r9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
